// File: rtl/move_collector_if.sv
// Bus bundle between the move collector, the square-unit array and the move sink.
// master: the collector (drives sq_sel/sq_rden and the move stream).
// slave : the environment (square array flags, muxed FIFO data, consumer ready).
// Signals: start, sq_done, sq_empty, sq_sel, sq_rden, sq_data,
//          mv_data, mv_valid, mv_ready, mv_count, busy, complete.
interface move_collector_if #(
   parameter int unsigned NSQ    = 64,
   parameter int unsigned DATA_W = 160,
   parameter int unsigned SLOT_W = 19,
   parameter int unsigned CNT_W  = 9
);
   localparam int unsigned SEL_W = $clog2(NSQ);

   logic              start;
   logic [NSQ-1:0]    sq_done;
   logic [NSQ-1:0]    sq_empty;
   logic [SEL_W-1:0]  sq_sel;
   logic [NSQ-1:0]    sq_rden;
   logic [DATA_W-1:0] sq_data;
   logic [SLOT_W-1:0] mv_data;
   logic              mv_valid;
   logic              mv_ready;
   logic [CNT_W-1:0]  mv_count;
   logic              busy;
   logic              complete;

   modport master (
      input  start, sq_done, sq_empty, sq_data, mv_ready,
      output sq_sel, sq_rden, mv_data, mv_valid, mv_count, busy, complete
   );

   modport slave (
      output start, sq_done, sq_empty, sq_data, mv_ready,
      input  sq_sel, sq_rden, mv_data, mv_valid, mv_count, busy, complete
   );
endinterface

// File: rtl/move_collector.sv
// Drain stage for the square-unit array: once every square reports done, it
// walks the square FIFOs in index order, pops each non-empty FIFO word by word,
// unpacks the eight 19-bit move slots and streams the valid ones out on a
// valid/ready interface with a saturating move count.
// Ports: clk, reset (async, active low), bus (move_collector_if.master).
// All bus outputs are registered and reset to zero.
module move_collector #(
   parameter int unsigned NSQ    = 64,
   parameter int unsigned SLOTS  = 8,
   parameter int unsigned SLOT_W = 19
) (
   input  logic              clk,
   input  logic              reset,
   move_collector_if.master  bus
);

   localparam int unsigned SEL_W   = $clog2(NSQ);
   localparam int unsigned SLOT_IW = $clog2(SLOTS);
   localparam int unsigned WORD_W  = SLOTS * SLOT_W;
   localparam int unsigned DATA_W  = 160;
   localparam int unsigned CNT_W   = 9;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_SCAN, S_READ, S_LATCH, S_EMIT, S_FIN
   } state_t;

   typedef logic [SLOTS-1:0][SLOT_W-1:0] word_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SLOT_IW-1:0] slot_q, slot_d;
   word_t              word_q, word_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NSQ-1:0]     rden_q, rden_d;
   logic [SLOT_W-1:0]  mv_data_q, mv_data_d;
   logic               mv_valid_q, mv_valid_d;
   logic               busy_q, busy_d;
   logic               complete_q, complete_d;
   logic [SLOT_W-1:0]  cur_slot;

   // Upper mux bits carry no slot data.
   logic unused_hi;
   assign unused_hi = ^bus.sq_data[DATA_W-1:WORD_W];

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         sel_q      <= '0;
         slot_q     <= '0;
         word_q     <= '0;
         cnt_q      <= '0;
         rden_q     <= '0;
         mv_data_q  <= '0;
         mv_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         complete_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         slot_q     <= slot_d;
         word_q     <= word_d;
         cnt_q      <= cnt_d;
         rden_q     <= rden_d;
         mv_data_q  <= mv_data_d;
         mv_valid_q <= mv_valid_d;
         busy_q     <= busy_d;
         complete_q <= complete_d;
      end
   end

   // Next state, then registered outputs derived from the next state so they
   // line up with the state they describe.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      slot_d     = slot_q;
      word_d     = word_q;
      cnt_d      = cnt_q;
      rden_d     = '0;
      mv_data_d  = mv_data_q;
      mv_valid_d = 1'b0;
      busy_d     = 1'b0;
      complete_d = 1'b0;
      cur_slot   = '0;

      unique case (state_q)
         S_IDLE, S_FIN: begin
            if (bus.start) begin
               state_d = S_WAIT;
               sel_d   = '0;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (&bus.sq_done) state_d = S_SCAN;
         end
         S_SCAN: begin
            if (!bus.sq_empty[sel_q])              state_d = S_READ;
            else if (sel_q == SEL_W'(NSQ - 1))     state_d = S_FIN;
            else                                   sel_d   = sel_q + SEL_W'(1);
         end
         S_READ: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            // FIFO q arrives one cycle after the read enable.
            word_d  = bus.sq_data[WORD_W-1:0];
            slot_d  = '0;
            state_d = S_EMIT;
         end
         S_EMIT: begin
            // Invalid slots retire at once; valid ones wait for the consumer.
            if (!mv_valid_q || bus.mv_ready) begin
               if (mv_valid_q && (cnt_q != CNT_W'(CNT_MAX))) cnt_d = cnt_q + CNT_W'(1);
               if (slot_q == SLOT_IW'(SLOTS - 1)) state_d = S_SCAN;
               else                               slot_d  = slot_q + SLOT_IW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      cur_slot   = word_d[slot_d];
      mv_valid_d = (state_d == S_EMIT) && !cur_slot[SLOT_W-1];
      if (mv_valid_d) mv_data_d = cur_slot;
      if (state_d == S_READ) rden_d[sel_d] = 1'b1;
      busy_d     = state_d inside {S_WAIT, S_SCAN, S_READ, S_LATCH, S_EMIT};
      complete_d = (state_d == S_FIN);
   end

   assign bus.sq_sel   = sel_q;
   assign bus.sq_rden  = rden_q;
   assign bus.mv_data  = mv_data_q;
   assign bus.mv_valid = mv_valid_q;
   assign bus.mv_count = cnt_q;
   assign bus.busy     = busy_q;
   assign bus.complete = complete_q;

endmodule

// File: tb/tb_move_collector.sv
// Self-checking bench for move_collector: FIFO array model, an expected move
// list derived from FIFO contents, a per-cycle compare process, and directed
// scenarios with literal expectations.
module tb_move_collector;

   localparam int unsigned NSQ    = 64;
   localparam int unsigned SLOTS  = 8;
   localparam int unsigned SLOT_W = 19;
   localparam int unsigned DATA_W = 160;
   localparam logic [SLOT_W-1:0] INV = 19'h40000;

   typedef logic [SLOTS-1:0][SLOT_W-1:0] word_t;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   move_collector_if #(.NSQ(NSQ), .DATA_W(DATA_W), .SLOT_W(SLOT_W)) bus();

   move_collector #(.NSQ(NSQ), .SLOTS(SLOTS), .SLOT_W(SLOT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   word_t             fifo [NSQ][$];
   int                rd_ptr [NSQ];
   logic              chk_en;
   logic [SLOT_W-1:0] exp_q [$];
   logic [SLOT_W-1:0] got_q [$];
   int                model_cnt = 0;
   logic              pending = 1'b0;
   logic [SLOT_W-1:0] prev_data = '0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic logic [SLOT_W-1:0] got_at(int i);
      if (got_q.size() > i) return got_q[i];
      return '1;
   endfunction

   function automatic word_t mk_run(logic [6:0] flag, logic [5:0] sq);
      word_t w;
      for (int k = 0; k < SLOTS; k++) w[k] = {flag, sq, 6'(k)};
      return w;
   endfunction

   // Square FIFO array: one-cycle read latency through the shared mux.
   always @(posedge clk) begin
      if (bus.start) begin
         for (int i = 0; i < NSQ; i++) rd_ptr[i] = 0;
      end else begin
         for (int i = 0; i < NSQ; i++) begin
            if (bus.sq_rden[i] && rd_ptr[i] < fifo[i].size()) begin
               bus.sq_data <= {8'hA5, fifo[i][rd_ptr[i]]};
               rd_ptr[i]++;
            end
         end
      end
      for (int i = 0; i < NSQ; i++) bus.sq_empty[i] <= (rd_ptr[i] >= fifo[i].size());
   end

   // Per-cycle compare against the move list and the saturating count.
   always @(negedge clk) begin
      if (!reset) begin
         pending   = 1'b0;
         model_cnt = 0;
      end else if (chk_en) begin
         check("mv_count", 64'(bus.mv_count), 64'(model_cnt));
         if (bus.sq_rden != '0) begin
            check("rden_onehot", bus.sq_rden, 64'd1 << bus.sq_sel);
            check("rden_nonempty", 64'(rd_ptr[bus.sq_sel] < fifo[bus.sq_sel].size()), 64'd1);
         end
         if (pending) begin
            check("stall_valid", 64'(bus.mv_valid), 64'd1);
            check("stall_data", 64'(bus.mv_data), 64'(prev_data));
         end
         if (bus.mv_valid) begin
            check("model_has_move", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("mv_data", 64'(bus.mv_data), 64'(exp_q[0]));
            if (bus.mv_ready) begin
               got_q.push_back(bus.mv_data);
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               if (model_cnt < 511) model_cnt++;
            end
         end
         if (bus.complete) begin
            check("complete_not_busy", 64'(bus.busy), 64'd0);
            check("complete_drained", 64'(exp_q.size()), 64'd0);
         end
         pending   = bus.mv_valid && !bus.mv_ready;
         prev_data = bus.mv_data;
         if (bus.start) begin
            model_cnt = 0;
            got_q.delete();
            exp_q.delete();
            for (int s = 0; s < NSQ; s++) begin
               for (int j = 0; j < fifo[s].size(); j++) begin
                  word_t wd;
                  wd = fifo[s][j];
                  for (int k = 0; k < SLOTS; k++)
                     if (!wd[k][SLOT_W-1]) exp_q.push_back(wd[k]);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_complete(input int bound, output int n);
      n = 0;
      while (!bus.complete && n < bound) begin
         tick();
         n++;
      end
      check("complete_within_bound", 64'(bus.complete), 64'd1);
   endtask

   task automatic clear_fifos();
      for (int i = 0; i < NSQ; i++) fifo[i].delete();
   endtask

   task automatic check_outputs_zero(string tag);
      check({tag, "_sq_sel"},   64'(bus.sq_sel),   64'd0);
      check({tag, "_sq_rden"},  bus.sq_rden,       64'd0);
      check({tag, "_mv_data"},  64'(bus.mv_data),  64'd0);
      check({tag, "_mv_valid"}, 64'(bus.mv_valid), 64'd0);
      check({tag, "_mv_count"}, 64'(bus.mv_count), 64'd0);
      check({tag, "_busy"},     64'(bus.busy),     64'd0);
      check({tag, "_complete"}, 64'(bus.complete), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      word_t w;
      int    n;
      int    seen;
      int    total;

      reset        = 1'b0;
      chk_en       = 1'b0;
      bus.start    = 1'b0;
      bus.sq_done  = '1;
      bus.mv_ready = 1'b1;
      repeat (3) tick();
      check_outputs_zero("reset");
      reset = 1'b1;
      tick();
      chk_en = 1'b1;

      // All FIFOs empty: WAIT + 64 SCAN + entry to FIN.
      clear_fifos();
      do_start();
      wait_complete(200, n);
      check("empty_latency", 64'(n + 1), 64'd66);
      check("empty_count", 64'(bus.mv_count), 64'd0);
      total = 0;
      for (int i = 0; i < NSQ; i++) total += rd_ptr[i];
      check("empty_no_reads", 64'(total), 64'd0);

      // Square 5, two valid slots, consumer always ready.
      clear_fifos();
      for (int k = 0; k < SLOTS; k++) w[k] = INV;
      w[0] = 19'h00A1C;
      w[3] = 19'h04B2D;
      fifo[5].push_back(w);
      bus.mv_ready = 1'b1;
      do_start();
      wait_complete(300, n);
      check("sq5_reads", 64'(rd_ptr[5]), 64'd1);
      check("sq5_moves", 64'(got_q.size()), 64'd2);
      check("sq5_first", 64'(got_at(0)), 64'h00A1C);
      check("sq5_second", 64'(got_at(1)), 64'h04B2D);
      check("sq5_count", 64'(bus.mv_count), 64'd2);

      // Same word, first move stalled three cycles.
      clear_fifos();
      fifo[5].push_back(w);
      bus.mv_ready = 1'b0;
      do_start();
      seen = 0;
      n    = 0;
      while (!bus.complete && n < 300) begin
         if (bus.mv_valid && bus.mv_data == 19'h00A1C) seen++;
         bus.mv_ready = (seen >= 4);
         tick();
         n++;
      end
      check("stall_complete", 64'(bus.complete), 64'd1);
      check("stall_hold_cycles", 64'(seen), 64'd4);
      check("stall_moves", 64'(got_q.size()), 64'd2);
      check("stall_second", 64'(got_at(1)), 64'h04B2D);
      check("stall_count", 64'(bus.mv_count), 64'd2);

      // Square 63 holds two full words.
      clear_fifos();
      fifo[63].push_back(mk_run(7'h2, 6'd63));
      fifo[63].push_back(mk_run(7'h3, 6'd63));
      bus.mv_ready = 1'b1;
      do_start();
      wait_complete(400, n);
      check("sq63_reads", 64'(rd_ptr[63]), 64'd2);
      check("sq63_moves", 64'(got_q.size()), 64'd16);
      check("sq63_first", 64'(got_at(0)), 64'h02FC0);
      check("sq63_last", 64'(got_at(15)), 64'h03FC7);
      check("sq63_count", 64'(bus.mv_count), 64'd16);

      // sq_done[10] low for 20 cycles holds WAIT; a later drop is ignored.
      clear_fifos();
      bus.sq_done     = '1;
      bus.sq_done[10] = 1'b0;
      do_start();
      for (int i = 0; i < 20; i++) begin
         check("wait_sel", 64'(bus.sq_sel), 64'd0);
         check("wait_busy", 64'(bus.busy), 64'd1);
         tick();
      end
      bus.sq_done[10] = 1'b1;
      tick();
      check("scan_first_sel", 64'(bus.sq_sel), 64'd0);
      tick();
      check("scan_second_sel", 64'(bus.sq_sel), 64'd1);
      bus.sq_done[10] = 1'b0;
      wait_complete(200, n);
      check("done_drop_ignored", 64'(bus.mv_count), 64'd0);
      bus.sq_done = '1;

      // Reset in the middle of EMIT with a move pending.
      clear_fifos();
      fifo[2].push_back(mk_run(7'h4, 6'd2));
      bus.mv_ready = 1'b0;
      do_start();
      n = 0;
      while (!bus.mv_valid && n < 200) begin
         tick();
         n++;
      end
      check("reach_emit", 64'(bus.mv_valid), 64'd1);
      chk_en = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      tick();
      reset = 1'b1;
      tick();
      tick();
      check("idle_after_reset_busy", 64'(bus.busy), 64'd0);
      check("idle_after_reset_complete", 64'(bus.complete), 64'd0);
      clear_fifos();
      for (int k = 0; k < SLOTS; k++) w[k] = INV;
      w[0] = 19'h00111;
      w[1] = 19'h00222;
      w[2] = 19'h00333;
      fifo[0].push_back(w);
      fifo[2].push_back(mk_run(7'h4, 6'd2));
      chk_en       = 1'b1;
      bus.mv_ready = 1'b1;
      do_start();
      check("restart_count", 64'(bus.mv_count), 64'd0);
      check("restart_sel", 64'(bus.sq_sel), 64'd0);
      wait_complete(400, n);
      check("restart_moves", 64'(got_q.size()), 64'd11);
      check("restart_first", 64'(got_at(0)), 64'h00111);
      check("restart_fourth", 64'(got_at(3)), 64'h04080);
      check("restart_total", 64'(bus.mv_count), 64'd11);

      // 520 moves: count saturates at 511 while moves keep flowing.
      clear_fifos();
      for (int s = 0; s < NSQ; s++) fifo[s].push_back(mk_run(7'h0, 6'(s)));
      fifo[0].push_back(mk_run(7'h1, 6'd0));
      bus.mv_ready = 1'b1;
      do_start();
      wait_complete(3000, n);
      check("sat_moves", 64'(got_q.size()), 64'd520);
      check("sat_count", 64'(bus.mv_count), 64'd511);
      check("sat_second_word", 64'(got_at(8)), 64'h01000);
      check("sat_last", 64'(got_at(519)), 64'h00FC7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/move_collector.md
# move_collector

Downstream drain stage for the 64-square move-generation array. After all square units report done, it scans their move FIFOs in square order (0 to 63) and pops every non-empty FIFO through a shared 160-bit read mux. Each popped word is unpacked into its eight 19-bit move slots, invalid slots are discarded, and valid moves go out one at a time on a valid/ready stream with a running move count. It sits between the square-unit array and the move-list storage/search logic.

## Interface

Parameters:
- NSQ, 64: number of square units scanned; sq_sel width is log2(NSQ).
- SLOTS, 8: move slots per FIFO word.
- SLOT_W, 19: bits per move slot, laid out as [7b flag][6b from][6b to]. Flag bit 18 is "invalid".

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a collection pass; honoured only in IDLE or FIN.
- sq_done  in  NSQ  done flag of each square unit.
- sq_empty  in  NSQ  FIFO empty flag of each square unit.
- sq_sel  out  6  index of the square whose FIFO output drives sq_data through the external mux.
- sq_rden  out  NSQ  FIFO read enables; at most one bit high, always bit sq_sel.
- sq_data  in  160  muxed FIFO output. Bits [151:0] hold slots 0–7; slot k = [19k+18:19k]. Bits [159:152] are ignored.
- mv_data  out  19  current move.
- mv_valid  out  1  mv_data holds a valid move.
- mv_ready  in  1  consumer accepts mv_data.
- mv_count  out  9  number of moves transferred this pass; saturates at 511.
- busy  out  1  high from the cycle after an accepted start until FIN.
- complete  out  1  high in FIN; held until the next start.

## Operation

States: IDLE, WAIT, SCAN, READ, LATCH, EMIT, FIN.

- **IDLE**
  - start moves to WAIT; sq_sel and mv_count are cleared.
- **WAIT**
  - Stays until &sq_done = 1, then moves to SCAN.
- **SCAN**
  - If sq_empty[sq_sel] = 0, go to READ.
  - Otherwise, if sq_sel = NSQ-1, go to FIN; else increment sq_sel and stay in SCAN.
- **READ**
  - sq_rden[sq_sel] = 1 for exactly this cycle, then go to LATCH.
- **LATCH**
  - Capture sq_data[151:0] into the word register, set slot = 0, go to EMIT.
- **EMIT**, examining slot k:
  - If bit 18 of slot k is 1, mv_valid = 0 and the slot is skipped in one cycle.
  - If bit 18 is 0, mv_valid = 1 and mv_data = slot k. The slot advances only when mv_valid & mv_ready, and mv_count increments on that cycle.
  - After slot 7 is retired, return to SCAN with sq_sel unchanged, so a FIFO holding several words is fully drained.
- **FIN**
  - complete = 1 and busy = 0.
  - start moves to WAIT; sq_sel and mv_count are cleared.
- start in WAIT, SCAN, READ, LATCH or EMIT is ignored.
- Moves are emitted in square order, then FIFO word order, then slot order 0→7.

## Timing

- Reset value of every output is 0: sq_sel, sq_rden, mv_data, mv_valid, mv_count, busy, complete.
- Reset clears all outputs immediately (asynchronous), including in the middle of EMIT. A pending move is dropped; the FSM enters IDLE.
- READ latency: sq_data is valid the cycle after sq_rden, matching the FIFO's one-cycle q latency. It is captured in LATCH.
- SCAN costs one cycle per empty square. A pass with every FIFO empty takes 64 SCAN cycles from WAIT exit to FIN.
- Per FIFO word: 1 READ + 1 LATCH + 8 EMIT cycles minimum (mv_ready held high), plus stall cycles.
- Backpressure:
  - While mv_valid & !mv_ready, mv_data and slot hold and mv_count does not change.
  - mv_valid never drops without a transfer.
- The word register holds the captured word through all of EMIT, even though sq_data may change.
- mv_count saturates at 511 and does not wrap; further moves are still emitted.
- &sq_done dropping after WAIT exit is ignored for the rest of the pass.

## Test plan

- All 64 FIFOs empty, sq_done all 1, start pulsed → no sq_rden pulse, complete rises exactly 66 cycles after start (WAIT + 64 SCAN + entry to FIN), mv_count = 0.
- Square 5 holds one word: slot 0 = 0x0_0A1C, slot 3 = 0x0_4B2D, other slots have bit 18 set; mv_ready = 1 → sq_rden[5] pulses once, mv_data = 0x0A1C then 0x4B2D in order, final mv_count = 2.
- Same stimulus with mv_ready = 0 for 3 cycles on the first move → mv_data = 0x0A1C stable for 4 cycles, single transfer, no duplicate, mv_count = 2.
- Square 63 holds two words of 8 valid moves each → sq_rden[63] pulses twice, 16 moves transferred, then complete = 1 with mv_count = 16.
- sq_done[10] = 0 for 20 cycles after start → sq_sel stays 0 and there is no SCAN progress until the cycle after sq_done[10] rises.
- reset driven low during EMIT with mv_valid = 1 → all outputs 0 before the next clk edge, FSM in IDLE; release reset, pulse start → the pass restarts from square 0 with mv_count = 0.
